// File: rtl/win_pkg.sv
// Shared types and constants for the register-window spill/fill engine.
package win_pkg;
  typedef enum logic [1:0] {IDLE, SPILL, FILL, GRANT} wsf_state_t;

  localparam int NUM_PHYS = 32;
  localparam int WIN_SIZE = 8;

  // win_add_sub encodings consumed by the register-file controller
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b01;
endpackage

// File: rtl/spill_stack_ptr.sv
// Spill stack pointer and depth counter; sp moves by whole windows, depth saturates.
module spill_stack_ptr #(
  parameter int          WIN_STEP   = 4,
  parameter logic [15:0] SPILL_BASE = 16'hF000,
  parameter int          MAX_DEPTH  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,        // spill finished: new top window
  input  logic        fill_start_i,  // fill begins: point sp at top window
  input  logic        fill_done_i,   // fill finished: top window consumed
  output logic [15:0] sp_o,
  output logic [6:0]  depth_o,
  output logic        full_o,
  output logic        empty_o
);
  logic [15:0] sp_q, sp_d;
  logic [6:0]  depth_q, depth_d;

  assign full_o  = (depth_q == 7'(MAX_DEPTH));
  assign empty_o = (depth_q == 7'd0);
  assign sp_o    = sp_q;
  assign depth_o = depth_q;

  // next-state: depth never passes 0 or MAX_DEPTH
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (push_i && !full_o) begin
      sp_d    = sp_q + 16'(WIN_STEP);
      depth_d = depth_q + 7'd1;
    end
    if (fill_start_i && !empty_o) sp_d = sp_q - 16'(WIN_STEP);
    if (fill_done_i && !empty_o)  depth_d = depth_q - 7'd1;
  end

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q    <= SPILL_BASE;
      depth_q <= 7'd0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end
endmodule

// File: rtl/window_spill_fill.sv
// Register-window spill/fill engine: saves the overlaid registers to a memory
// stack on call overflow and restores them on return into a spilled window.
module window_spill_fill
  import win_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          WIN_STEP   = 4,
  parameter int          WIN_MAX    = 24,
  parameter logic [15:0] SPILL_BASE = 16'hF000,
  parameter int          MAX_DEPTH  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       win_index,
  input  logic             call_req,
  input  logic             ret_req,
  output logic             win_go,
  output logic             stall,
  output logic [4:0]       rf_sel,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             rf_we,
  output logic [15:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [6:0]       depth,
  output logic             fault
);
  localparam int KW = (WIN_STEP > 1) ? $clog2(WIN_STEP) : 1;

  wsf_state_t  state_q;
  logic [KW-1:0] k_q;
  logic        fault_q;
  logic [15:0] sp;
  logic        full, empty;

  logic at_max, at_zero, only_call, only_ret, start_spill, start_fill;
  logic last_beat, push, fill_done;

  assign at_max      = (win_index == 5'(WIN_MAX));
  assign at_zero     = (win_index == 5'd0);
  assign only_call   = call_req && !ret_req;
  assign only_ret    = ret_req && !call_req;
  assign start_spill = (state_q == IDLE) && only_call && at_max && !full;
  assign start_fill  = (state_q == IDLE) && only_ret && at_zero && !empty;
  assign last_beat   = (k_q == KW'(WIN_STEP - 1));
  assign push        = (state_q == SPILL) && mem_ready && last_beat;
  assign fill_done   = (state_q == FILL) && mem_ready && last_beat;
  assign fault       = fault_q;

  spill_stack_ptr #(
    .WIN_STEP  (WIN_STEP),
    .SPILL_BASE(SPILL_BASE),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_ssp (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .fill_start_i(start_fill),
    .fill_done_i (fill_done),
    .sp_o        (sp),
    .depth_o     (depth),
    .full_o      (full),
    .empty_o     (empty)
  );

  // control FSM: beat counter advances only on accepted memory beats
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          k_q <= '0;
          if (call_req && ret_req) fault_q <= 1'b1;
          else if (only_call && at_max && full) fault_q <= 1'b1;
          else if (start_spill) state_q <= SPILL;
          else if (start_fill)  state_q <= FILL;
        end
        SPILL, FILL: begin
          if (mem_ready) begin
            if (last_beat) begin
              state_q <= GRANT;
              k_q     <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        GRANT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // output decode; IDLE grants pass straight through in the request cycle
  always_comb begin
    win_go    = 1'b0;
    stall     = 1'b0;
    rf_sel    = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        win_go = !reset && ((only_call && (!at_max || full)) ||
                            (only_ret && (!at_zero || empty)));
      end
      SPILL: begin
        stall     = 1'b1;
        rf_sel    = win_index + 5'(WIN_SIZE) + 5'(k_q);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp + 16'(k_q);
        mem_wdata = rf_rdata;
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = sp + 16'(k_q);
        if (mem_ready) begin
          rf_sel   = win_index - 5'(WIN_STEP) + 5'(k_q);
          rf_wdata = mem_rdata;
          rf_we    = 1'b1;
        end
      end
      GRANT: win_go = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_window_spill_fill.sv
// Bench for window_spill_fill: acts as register file, memory and processor,
// and checks against a window-level model of the spill stack.
module tb_window_spill_fill;
  localparam int WIDTH = 16, WIN_STEP = 4, WIN_MAX = 24, MAX_DEPTH = 64;
  localparam int BASE = 'hF000;

  logic             clock = 1'b0, reset = 1'b1;
  logic [4:0]       win_index = '0;
  logic             call_req = 1'b0, ret_req = 1'b0;
  logic             win_go, stall, rf_we, mem_req, mem_we, fault;
  logic [4:0]       rf_sel;
  logic [WIDTH-1:0] rf_rdata, rf_wdata, mem_wdata, mem_rdata;
  logic [15:0]      mem_addr;
  logic             mem_ready = 1'b1;
  logic [6:0]       depth;

  window_spill_fill #(.WIDTH(WIDTH), .WIN_STEP(WIN_STEP), .WIN_MAX(WIN_MAX),
                      .SPILL_BASE(16'hF000), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clock(clock), .reset(reset), .win_index(win_index), .call_req(call_req),
    .ret_req(ret_req), .win_go(win_go), .stall(stall), .rf_sel(rf_sel),
    .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ready(mem_ready), .depth(depth), .fault(fault));

  always #5 clock = ~clock;

  // environment: physical register file and data memory
  logic [15:0] regs [0:31];
  logic [15:0] mem  [0:511];
  logic        proc_we = 1'b0;
  logic [4:0]  proc_sel = '0;
  logic [15:0] proc_data = '0;
  assign rf_rdata  = regs[rf_sel];
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clock) begin
    if (rf_we) regs[rf_sel] <= rf_wdata;
    if (proc_we) regs[proc_sel] <= proc_data;
    if (mem_req && mem_we && mem_ready) mem[mem_addr[8:0]] <= mem_wdata;
  end

  // reference model: stack of saved windows
  int  m_regs [32];
  int  m_mem  [512];
  bit  m_valid[512];
  int  m_sp, m_depth;
  bit  m_fault;
  int  n_pass = 0, n_tot = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp_v);
  endfunction

  task automatic model(input logic [4:0] w, input bit c, input bit r, output int lat, output bit xfer);
    xfer = 0; lat = 0;
    if (c && r) begin
      m_fault = 1; lat = -1;
    end else if (c && w == 5'(WIN_MAX)) begin
      if (m_depth == MAX_DEPTH) m_fault = 1;
      else begin
        for (int k = 0; k < WIN_STEP; k++) begin
          m_mem[m_sp - BASE + k]   = m_regs[(int'(w) + 8 + k) % 32];
          m_valid[m_sp - BASE + k] = 1;
        end
        m_sp += WIN_STEP; m_depth++; xfer = 1; lat = WIN_STEP + 1;
      end
    end else if (r && w == 0 && m_depth > 0) begin
      m_sp -= WIN_STEP;
      for (int k = 0; k < WIN_STEP; k++)
        m_regs[(int'(w) + 32 - WIN_STEP + k) % 32] = m_mem[m_sp - BASE + k];
      m_depth--; xfer = 1; lat = WIN_STEP + 1;
    end
  endtask

  task automatic model_reset();
    m_sp = BASE; m_depth = 0; m_fault = 0;
  endtask

  task automatic set_reg(input int idx, input logic [15:0] val);
    proc_we = 1; proc_sel = 5'(idx); proc_data = val; m_regs[idx] = int'(val);
    @(negedge clock);
    proc_we = 0;
  endtask

  // one processor request, held until granted; called and returns at a negedge
  bit rdy_q[$];
  bit rnd_rdy = 0;
  int t_lat, t_stalls, t_beats;
  logic [15:0] t_hold_addr;
  task automatic do_txn(input logic [4:0] w, input bit c, input bit r);
    logic [15:0] pa, pd;
    bit phold, done;
    win_index = w; call_req = c; ret_req = r;
    t_lat = -1; t_stalls = 0; t_beats = 0; phold = 0; done = 0; pa = '0; pd = '0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (rdy_q.size() > 0) mem_ready = rdy_q.pop_front();
      else mem_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (phold) begin
        chk("hold addr", 32'(mem_addr), 32'(pa));
        chk("hold data", 32'(mem_wdata), 32'(pd));
      end
      phold = stall && !mem_ready;
      pa = mem_addr; pd = mem_wdata;
      if (phold) t_hold_addr = mem_addr;
      if (stall) begin t_stalls++; if (mem_ready) t_beats++; end
      if (win_go) begin t_lat = i; done = 1; end
      else if (c && r && i == 3) done = 1;
      @(negedge clock);
    end
    call_req = 0; ret_req = 0;
  endtask

  task automatic check_state(input string tag);
    int e = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== 16'(m_regs[i])) e++;
    for (int j = 0; j < 512; j++) if (m_valid[j] && mem[j] !== 16'(m_mem[j])) e++;
    chk({tag, " regs/mem"}, 32'(e), 0);
    chk({tag, " depth"}, 32'(depth), 32'(m_depth));
    chk({tag, " fault"}, 32'(fault), 32'(m_fault));
  endtask

  task automatic run(input logic [4:0] w, input bit c, input bit r, input string tag);
    int exp_lat; bit xfer;
    model(w, c, r, exp_lat, xfer);
    do_txn(w, c, r);
    chk({tag, " beats"}, 32'(t_beats), xfer ? WIN_STEP : 0);
    chk({tag, " latency"}, 32'(t_lat), xfer ? 32'(exp_lat + t_stalls - t_beats) : 32'(exp_lat));
    check_state(tag);
  endtask

  // single-cycle IDLE response, request withdrawn before the clock edge
  typedef struct { logic [4:0] w; bit c; bit r; bit g0; bit g1; } vec_t;
  vec_t tbl[10];
  task automatic apply_table(input bit d1);
    mem_ready = 1;
    foreach (tbl[i]) begin
      win_index = tbl[i].w; call_req = tbl[i].c; ret_req = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d/%0d go", i, d1), 32'(win_go), 32'(d1 ? tbl[i].g1 : tbl[i].g0));
      chk($sformatf("tbl%0d/%0d stall", i, d1), 32'(stall), 0);
      chk($sformatf("tbl%0d/%0d memreq", i, d1), 32'(mem_req), 0);
      #1;
      call_req = 0; ret_req = 0;
      @(negedge clock);
    end
  endtask

  initial begin
    tbl = '{'{5'd8,  1'b1, 1'b0, 1'b1, 1'b1},
            '{5'd24, 1'b1, 1'b0, 1'b0, 1'b0},
            '{5'd0,  1'b0, 1'b1, 1'b1, 1'b0},
            '{5'd12, 1'b0, 1'b1, 1'b1, 1'b1},
            '{5'd0,  1'b1, 1'b0, 1'b1, 1'b1},
            '{5'd24, 1'b0, 1'b1, 1'b1, 1'b1},
            '{5'd5,  1'b1, 1'b1, 1'b0, 1'b0},
            '{5'd0,  1'b1, 1'b1, 1'b0, 1'b0},
            '{5'd31, 1'b1, 1'b0, 1'b1, 1'b1},
            '{5'd4,  1'b0, 1'b0, 1'b0, 1'b0}};
    model_reset();
    call_req = 1;  // reset must mask the grant
    repeat (2) @(negedge clock);
    #1;
    chk("rst stall", 32'(stall), 0);
    chk("rst win_go", 32'(win_go), 0);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst rf_we", 32'(rf_we), 0);
    chk("rst depth", 32'(depth), 0);
    chk("rst fault", 32'(fault), 0);
    call_req = 0;
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 32; i++) set_reg(i, 16'($urandom));

    apply_table(0);
    set_reg(0, 16'h1111); set_reg(1, 16'h2222); set_reg(2, 16'h3333); set_reg(3, 16'h4444);
    run(5'd24, 1, 0, "spill");
    chk("spill lat5", 32'(t_lat), 5);
    chk("spill F002", 32'(mem[9'h002]), 32'h3333);
    apply_table(1);
    run(5'd0, 0, 1, "fill");
    chk("fill r28", 32'(regs[28]), 32'h1111);
    chk("fill r31", 32'(regs[31]), 32'h4444);

    rdy_q = '{1, 1, 1, 0, 0, 0, 1, 1};
    run(5'd24, 1, 0, "hold");
    chk("hold stalls", 32'(t_stalls), 7);
    chk("hold lat", 32'(t_lat), 8);
    chk("hold at F002", 32'(t_hold_addr), 32'hF002);
    run(5'd0, 0, 1, "fill2");

    run(5'd7, 1, 1, "both");
    chk("both stalls", 32'(t_stalls), 0);
    reset = 1; @(negedge clock); reset = 0; model_reset();
    #1 chk("fault clr", 32'(fault), 0);
    @(negedge clock);

    rnd_rdy = 1;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      set_reg($urandom_range(0, 31), 16'($urandom));
      run(5'd24, 1, 0, "fill64");
    end
    run(5'd24, 1, 0, "full");
    chk("full fault", 32'(fault), 1);
    chk("full go now", 32'(t_lat), 0);

    for (int i = 0; i < 60; i++) begin
      int sw, sc;
      logic [4:0] w;
      set_reg($urandom_range(0, 31), 16'($urandom));
      sw = $urandom_range(0, 3); sc = $urandom_range(0, 9);
      w = (sw == 0) ? 5'd24 : (sw == 1) ? 5'd0 : 5'($urandom);
      run(w, (sc == 0) || (sc < 5), (sc == 0) || (sc >= 5), "rand");
    end

    rnd_rdy = 0;
    if (m_depth == 0) run(5'd24, 1, 0, "pre-rst");
    win_index = 0; ret_req = 1; mem_ready = 1;
    @(negedge clock); #1;
    chk("fb0 stall", 32'(stall), 1);
    chk("fb0 rf_we", 32'(rf_we), 1);
    chk("fb0 rf_sel", 32'(rf_sel), 28);
    @(negedge clock);
    reset = 1;
    @(negedge clock); #1;
    chk("mrst stall", 32'(stall), 0);
    chk("mrst depth", 32'(depth), 0);
    chk("mrst rf_we", 32'(rf_we), 0);
    chk("mrst mem_req", 32'(mem_req), 0);
    chk("mrst fault", 32'(fault), 0);
    reset = 0; ret_req = 0;
    model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = int'(regs[i]);  // partial fill left in place
    @(negedge clock);
    run(5'd24, 1, 0, "post-rst");
    chk("post-rst F000", 32'(mem[9'h000]), 32'(regs[0]));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
